tx_mac_framer: RTL

- Downstream neighbour of the TX byte-control stage: consumes its per-byte stream (data, valid, last) and returns the ready handshake.
- Emits a complete Ethernet frame on a GMII-style 8-bit interface: preamble, SFD, payload, zero-pad to minimum length, optional FCS, then inter-frame gap.
- Provides underrun and oversize protection, plus a sent-frame counter.

---
 rtl/eth_tx_pkg.sv | 32 +++
 rtl/crc32_d8.sv | 24 ++
 rtl/tx_mac_framer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet TX framer: FSM state encoding,
// framing byte constants and CRC-32 constants.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // LSB-first shift register form needs the bit-reversed polynomial
  localparam logic [31:0] ETH_CRC_POLY_REFL = reflect32(ETH_CRC_POLY);

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Only built when TX_MAC_FRAMER_FCS_EN is defined (the FCS option).
`ifdef TX_MAC_FRAMER_FCS_EN
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc ^ {24'h000000, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ ETH_CRC_POLY_REFL) : (w_c >> 1);
    end
  end

  assign o_crc = w_c;

endmodule
`endif

// File: rtl/tx_mac_framer.sv
// Ethernet TX framer: preamble/SFD, payload, zero pad, optional FCS, IFG.
// Define TX_MAC_FRAMER_FCS_EN to compute and append the 4-byte FCS.
module tx_mac_framer
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        tx_mac_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  localparam logic [15:0] LP_MIN      = 16'(MIN_PAYLOAD);
  localparam logic [15:0] LP_MAX      = 16'(MAX_PAYLOAD);
  localparam logic [7:0]  LP_PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  LP_IFG_LAST = 8'(IFG_CYCLES - 1);
`ifdef TX_MAC_FRAMER_FCS_EN
  localparam tx_state_e   ST_AFTER_BODY = ST_FCS;
`else
  localparam tx_state_e   ST_AFTER_BODY = ST_IFG;
`endif

  tx_state_e   r_state, w_state_next;
  logic [7:0]  r_cnt;
  logic [15:0] r_byte_cnt, w_byte_cnt_inc;
  logic [7:0]  r_txd, w_txd_next, w_fcs_byte;
  logic        r_tx_en, w_tx_en_next, r_tx_er, w_tx_er_next;
  logic        r_underrun, w_underrun_next;
  logic [15:0] r_frames_sent;
  logic        w_xfer, w_oversize, w_short, w_frame_done;

  assign w_byte_cnt_inc = r_byte_cnt + 16'd1;
  assign w_oversize     = (r_byte_cnt == LP_MAX);
  assign w_short        = (w_byte_cnt_inc < LP_MIN);
  assign w_xfer         = (r_state == ST_DATA) && in_valid && !w_oversize;

`ifdef TX_MAC_FRAMER_FCS_EN
  logic [31:0] r_crc, w_crc_next;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_txd_next),
    .o_crc  (w_crc_next)
  );

  assign w_fcs_byte = ~r_crc[{r_cnt[1:0], 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= ETH_CRC_INIT;
    end else if (w_state_next == ST_PREAMBLE && r_state != ST_PREAMBLE) begin
      r_crc <= ETH_CRC_INIT;
    end else if (w_xfer || r_state == ST_PAD) begin
      r_crc <= w_crc_next;
    end
  end
`else
  assign w_fcs_byte = 8'h00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (in_valid) w_state_next = ST_PREAMBLE;
      ST_PREAMBLE: if (r_cnt == LP_PRE_LAST) w_state_next = ST_SFD;
      ST_SFD:      w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_oversize || !in_valid) w_state_next = ST_IFG;
        else if (in_last)            w_state_next = w_short ? ST_PAD : ST_AFTER_BODY;
      end
      ST_PAD:      if (!w_short) w_state_next = ST_AFTER_BODY;
      ST_FCS:      if (r_cnt == 8'd3) w_state_next = ST_IFG;
      // Back-to-back frames skip IDLE so the gap is exactly IFG_CYCLES
      ST_IFG:      if (r_cnt == LP_IFG_LAST) w_state_next = in_valid ? ST_PREAMBLE : ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_txd_next      = 8'h00;
    w_tx_en_next    = 1'b0;
    w_tx_er_next    = 1'b0;
    w_underrun_next = 1'b0;
    case (r_state)
      ST_PREAMBLE: begin
        w_txd_next   = ETH_PREAMBLE_BYTE;
        w_tx_en_next = 1'b1;
      end
      ST_SFD: begin
        w_txd_next   = ETH_SFD_BYTE;
        w_tx_en_next = 1'b1;
      end
      ST_DATA: begin
        w_tx_en_next = 1'b1;
        if (w_oversize || !in_valid) begin
          w_tx_er_next    = 1'b1;
          w_underrun_next = !w_oversize;
        end else begin
          w_txd_next = in_data;
        end
      end
      ST_PAD:  w_tx_en_next = 1'b1;
      ST_FCS: begin
        w_txd_next   = w_fcs_byte;
        w_tx_en_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Any entry into IFG without the error marker is a normal frame end
  assign w_frame_done = (w_state_next == ST_IFG) && (r_state != ST_IFG) && !w_tx_er_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txd         <= 8'h00;
      r_tx_en       <= 1'b0;
      r_tx_er       <= 1'b0;
      r_underrun    <= 1'b0;
      r_cnt         <= 8'd0;
      r_byte_cnt    <= 16'd0;
      r_frames_sent <= 16'd0;
    end else begin
      r_txd      <= w_txd_next;
      r_tx_en    <= w_tx_en_next;
      r_tx_er    <= w_tx_er_next;
      r_underrun <= w_underrun_next;
      r_cnt      <= (w_state_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      if (w_state_next == ST_PREAMBLE && r_state != ST_PREAMBLE)
        r_byte_cnt <= 16'd0;
      else if (w_xfer || r_state == ST_PAD)
        r_byte_cnt <= w_byte_cnt_inc;
      if (w_frame_done)
        r_frames_sent <= r_frames_sent + 16'd1;
    end
  end

  assign tx_mac_ready = (r_state == ST_DATA);
  assign busy         = (r_state != ST_IDLE);
  assign gmii_txd     = r_txd;
  assign gmii_tx_en   = r_tx_en;
  assign gmii_tx_er   = r_tx_er;
  assign underrun     = r_underrun;
  assign frames_sent  = r_frames_sent;

endmodule
